// File: rtl/hazard_pkg.sv
// Shared definitions for the RV32I pipeline hazard controller.
//   - RV32I major opcodes used to classify instructions
//   - forwarding-select encodings for the EX operand muxes
//   - controller FSM state type
//   - per-stage decoded-instruction struct and the forwarding-select helper
package hazard_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_STALL,
    ST_FLUSH,
    ST_MEM_WAIT
  } state_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes_rd;  // already false when rd == x0
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
  } dec_t;

  // Operand source for one EX register read; MEM wins over WB because it
  // holds the younger write.
  function automatic logic [1:0] fwd_sel(input logic       use_rs,
                                         input logic [4:0] rs,
                                         input dec_t       mem,
                                         input dec_t       wb);
    if (!use_rs)                          return FWD_NONE;
    if (mem.writes_rd && (mem.rd == rs))  return FWD_MEM;
    if (wb.writes_rd  && (wb.rd  == rs))  return FWD_WB;
    return FWD_NONE;
  endfunction

endpackage

// File: rtl/hazard_decode.sv
// Register-field decoder for one pipeline stage.
//   inst_i : 32-bit instruction word held in the stage
//   dec_o  : rd/rs1/rs2 plus writes_rd/uses_rs1/uses_rs2/is_load flags
module hazard_decode
  import hazard_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [6:0] op;
  logic       unused_bits;

  assign op          = inst_i[6:0];
  assign unused_bits = ^{inst_i[31:25], inst_i[14:12]};

  always_comb begin
    dec_o.rd        = inst_i[11:7];
    dec_o.rs1       = inst_i[19:15];
    dec_o.rs2       = inst_i[24:20];
    // A write to x0 is discarded, so it can never be a hazard source.
    dec_o.writes_rd = (op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR,
                                  OP_LUI, OP_AUIPC}) && (inst_i[11:7] != 5'd0);
    dec_o.uses_rs1  = op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    dec_o.uses_rs2  = op inside {OP_R, OP_STORE, OP_BRANCH};
    dec_o.is_load   = (op == OP_LOAD);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core.
//   clk, rstn        : clock, asynchronous active-high reset
//   id/ex/mem/wb_inst: instruction word held in each stage
//   ex_redirect      : EX resolved a taken branch / JAL / JALR
//   dmem_busy        : data memory not ready for the MEM access
//   pc_we, ifid_we   : PC and IF/ID write enables
//   ifid_flush       : load NOP into IF/ID
//   idex_bubble      : load NOP into ID/EX
//   exmem_hold       : freeze EX/MEM and MEM/WB
//   fwd_a, fwd_b     : EX operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   stall_cnt        : saturating count of stall/hold cycles
//   flush_cnt        : saturating count of accepted redirects
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      ex_inst,
  input  logic [31:0]      mem_inst,
  input  logic [31:0]      wb_inst,
  input  logic             ex_redirect,
  input  logic             dmem_busy,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Remaining FLUSH-state cycles after the redirect cycle itself.
  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  dec_t id_dec, ex_dec, mem_dec, wb_dec;

  hazard_decode u_dec_id  (.inst_i(id_inst),  .dec_o(id_dec));
  hazard_decode u_dec_ex  (.inst_i(ex_inst),  .dec_o(ex_dec));
  hazard_decode u_dec_mem (.inst_i(mem_inst), .dec_o(mem_dec));
  hazard_decode u_dec_wb  (.inst_i(wb_inst),  .dec_o(wb_dec));

  logic unused_dec;
  assign unused_dec = ^{id_dec.rd, id_dec.writes_rd, id_dec.is_load,
                        mem_dec.rs1, mem_dec.rs2, mem_dec.uses_rs1,
                        mem_dec.uses_rs2, mem_dec.is_load,
                        wb_dec.rs1, wb_dec.rs2, wb_dec.uses_rs1,
                        wb_dec.uses_rs2, wb_dec.is_load};

  // Load in EX whose result ID needs next cycle.
  logic load_use;
  assign load_use = ex_dec.is_load && ex_dec.writes_rd &&
                    ((id_dec.uses_rs1 && (id_dec.rs1 == ex_dec.rd)) ||
                     (id_dec.uses_rs2 && (id_dec.rs2 == ex_dec.rd)));

  state_e          state_q, state_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Next state. A redirect held off by dmem_busy stays on ex_redirect
  // because EX is frozen, so it is taken once busy drops.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (dmem_busy) begin
      state_d = ST_MEM_WAIT;
    end else if (ex_redirect) begin
      fcnt_d  = FLUSH_LOAD;
      state_d = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN:   if (load_use) state_d = ST_LOAD_STALL;
        ST_FLUSH: begin
          // fcnt_q counts FLUSH cycles left including this one.
          fcnt_d = fcnt_q - 2'd1;
          if (fcnt_q <= 2'd1) begin
            state_d = ST_RUN;
            fcnt_d  = '0;
          end
        end
        default:  state_d = ST_RUN;
      endcase
    end
  end

  logic stall_evt, flush_evt;
  assign stall_evt = dmem_busy ||
                     ((state_q == ST_RUN) && load_use && !ex_redirect);
  assign flush_evt = ex_redirect && !dmem_busy;

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_evt && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (flush_evt && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // Pipeline control, Mealy on state and the live hazard inputs.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    fwd_a       = fwd_sel(ex_dec.uses_rs1, ex_dec.rs1, mem_dec, wb_dec);
    fwd_b       = fwd_sel(ex_dec.uses_rs2, ex_dec.rs2, mem_dec, wb_dec);
    if (rstn) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fwd_a       = FWD_NONE;
      fwd_b       = FWD_NONE;
    end else if (dmem_busy) begin
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      exmem_hold = 1'b1;
    end else if (ex_redirect || (state_q == ST_FLUSH)) begin
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state_q == ST_RUN) && load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32I core; sequences PC/IF-ID/ID-EX/EX-MEM register enables around data, control and memory hazards.
- Produces the EX-stage operand forwarding selects (EX/MEM and MEM/WB sources), load-use stalls, taken-branch flushes and data-memory wait holds.
- Sits beside the pipeline registers and is driven from the instruction word held in each stage.

Parameters:
- FLUSH_CYCLES, 2, number of cycles IF/ID and ID/EX are flushed after a taken branch or jump (1..3).
- CNT_W, 16, width of the saturating performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- rstn  in  1  reset: asynchronous, active-high.
- id_inst  in  32  instruction in ID.
- ex_inst  in  32  instruction in EX.
- mem_inst  in  32  instruction in MEM.
- wb_inst  in  32  instruction in WB.
- ex_redirect  in  1  EX resolved taken branch, JAL or JALR this cycle.
- dmem_busy  in  1  data memory not ready for the access in MEM.
- pc_we  out  1  PC write enable.
- ifid_we  out  1  IF/ID write enable.
- ifid_flush  out  1  load NOP into IF/ID.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_hold  out  1  freeze EX/MEM and MEM/WB.
- fwd_a  out  2  rs1 operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  rs2 operand select, same encoding.
- stall_cnt  out  CNT_W  cycles spent in LOAD_STALL or MEM_WAIT.
- flush_cnt  out  CNT_W  number of redirects accepted.

Behaviour:
- Opcode classes:
  - Writes rd: 0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111.
  - Uses rs1: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111.
  - Uses rs2: 0110011, 0100011, 1100011.
  - rd == x0 never creates a hazard.
- Forwarding (combinational, every cycle):
  - fwd_a = 10 if mem_inst writes rd, rd != 0 and rd == ex_inst rs1.
  - Otherwise fwd_a = 01 if wb_inst matches the same way.
  - Otherwise fwd_a = 00.
  - fwd_b is identical on rs2.
  - MEM has priority over WB.
  - fwd is 00 when the EX instruction does not use that operand.
- FSM states: RUN, LOAD_STALL, FLUSH, MEM_WAIT. Reset state is RUN.
- Transition priority, evaluated each cycle: dmem_busy > ex_redirect > load-use > stay.
  - RUN:
    - dmem_busy → MEM_WAIT.
    - Else ex_redirect → FLUSH, counter loaded with FLUSH_CYCLES-1.
    - Else load-use → LOAD_STALL. Load-use means ex_inst opcode 0000011, rd != 0, and rd equals a used rs1/rs2 of id_inst.
    - Else stay in RUN.
  - LOAD_STALL: lasts exactly 1 cycle, then → RUN (or MEM_WAIT/FLUSH per priority).
  - FLUSH: counter decrements each cycle; at 0 → RUN.
  - MEM_WAIT: stay while dmem_busy; on deassert → RUN. A redirect seen during MEM_WAIT is not lost: the pipeline is frozen, so EX re-presents it.
- Outputs (Mealy on current state plus the detect/redirect/busy inputs):
  - dmem_busy (any state): pc_we=0, ifid_we=0, exmem_hold=1, idex_bubble=0, ifid_flush=0.
  - Redirect, or state FLUSH: pc_we=1, ifid_flush=1, idex_bubble=1.
  - Load-use in RUN: pc_we=0, ifid_we=0, idex_bubble=1.
  - Otherwise: pc_we=1, ifid_we=1, all others 0.
- Reset values while rstn=1: state RUN, counters 0, pc_we=0, ifid_we=0, ifid_flush=1, idex_bubble=1, exmem_hold=0, fwd_a=fwd_b=00.
- Counters:
  - stall_cnt increments each cycle the stall or hold condition is asserted.
  - flush_cnt increments once per redirect accepted (not in MEM_WAIT).
  - Both saturate at all-ones; no wrap.
- Reset asserted mid-operation (any state) aborts immediately to RUN. No state survives.

Decomposition:
- Shared package hazard_pkg holds:
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC.
  - State enum.
  - FWD_NONE/FWD_MEM/FWD_WB encodings.
- One sub-module, hazard_decode: from a 32-bit instruction it extracts rd/rs1/rs2 plus writes_rd/uses_rs1/uses_rs2. It is instantiated once per stage.

Test Plan:
- ex=add x5,x1,x2; mem=addi x1,x0,3; wb=addi x1,x0,7 → fwd_a=10 (MEM priority), fwd_b=00.
- Redirect with destination x0: mem=addi x0,x0,1, ex uses rs1=x0 → fwd_a=00.
- ex=lw x6,0(x2), id=add x7,x6,x3 → 1 cycle pc_we=0, ifid_we=0, idex_bubble=1, then RUN; stall_cnt=1.
- ex_redirect pulse, FLUSH_CYCLES=2 → ifid_flush=idex_bubble=1 for 2 cycles, pc_we=1; flush_cnt=1.
- dmem_busy held 3 cycles concurrent with ex_redirect → exmem_hold=1 for 3 cycles; redirect honoured on cycle 4; stall_cnt=3.
- rstn pulsed during FLUSH → next cycle state RUN, counters 0, outputs at reset values.
